// File: rtl/dsp_wb_regs.sv
// Wishbone register/program-store bridge between the CPU data bus and the audio DSP.
// Optional feature: define DSP_COEF_READBACK_EN to make COEF-region reads return store words.
module dsp_wb_regs #(
  parameter int          PROG_AW    = 8,
  parameter int          RST_LEN    = 4,
  parameter logic [7:0]  ADR_COEF   = 8'h60,
  parameter logic [7:0]  ADR_STATUS = 8'h62,
  parameter logic [7:0]  ADR_RESET  = 8'h63
) (
  input  logic               ck,
  input  logic               rst_n,
  input  logic               wb_dbus_cyc,
  input  logic               wb_dbus_we,
  input  logic [3:0]         wb_dbus_sel,
  input  logic [31:0]        wb_dbus_adr,
  input  logic [31:0]        wb_dbus_dat,
  output logic               ack,
  output logic [31:0]        rdt,
  input  logic [PROG_AW-1:0] fetch_addr,
  output logic [31:0]        fetch_data,
  input  logic               capt_we,
  input  logic [31:0]        capt_data,
  input  logic               engine_ready,
  output logic               dsp_rst,
  output logic               allow_audio
);

  localparam int CW = $clog2(RST_LEN + 1);

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [7:0]  region;
    logic [21:0] off;   // word offset within the region
    logic [31:0] dat;
  } req_t;

  logic [31:0]   mem [2**PROG_AW];
  req_t          req_q;
  logic          held, fire;
  logic [CW-1:0] cnt;
  logic [31:0]   capt_q, rd_data;
  logic          coef_wr, rst_wr, ctl_wr;
  logic          unused_adr;

  assign unused_adr = ^wb_dbus_adr[1:0];

  // One transfer per cyc assertion: held blocks re-acceptance until cyc is seen low.
  assign fire    = wb_dbus_cyc & ~ack & ~held;
  assign dsp_rst = (cnt != '0);

  // Writes commit on the edge that closes the ack cycle, from the request latched at accept.
  assign coef_wr = ack & req_q.we & (req_q.region == ADR_COEF);
  assign rst_wr  = ack & req_q.we & (req_q.region == ADR_RESET);
  assign ctl_wr  = ack & req_q.we & (req_q.region == ADR_STATUS) & (req_q.off == 22'd0);

  always_comb begin
    rd_data = '0;
    if (wb_dbus_adr[31:24] == ADR_STATUS) begin
      if (wb_dbus_adr[23:2] == 22'd0)
        rd_data = {29'b0, dsp_rst, allow_audio, engine_ready};
      else if (wb_dbus_adr[23:2] == 22'd1)
        rd_data = capt_q;
    end
`ifdef DSP_COEF_READBACK_EN
    else if (wb_dbus_adr[31:24] == ADR_COEF)
      rd_data = mem[wb_dbus_adr[PROG_AW+1:2]];
`endif
  end

  always_ff @(posedge ck) begin
    if (!rst_n) begin
      ack         <= 1'b0;
      held        <= 1'b0;
      req_q       <= '0;
      rdt         <= '0;
      cnt         <= '0;
      allow_audio <= 1'b0;
      capt_q      <= '0;
      fetch_data  <= '0;
    end else begin
      ack  <= fire;
      held <= wb_dbus_cyc & (held | ack);
      if (fire)
        req_q <= '{we: wb_dbus_we, sel: wb_dbus_sel, region: wb_dbus_adr[31:24],
                   off: wb_dbus_adr[23:2], dat: wb_dbus_dat};
      rdt <= (fire && !wb_dbus_we) ? rd_data : '0;
      if (capt_we)
        capt_q <= capt_data;
      if (rst_wr)
        cnt <= CW'(RST_LEN);
      else if (dsp_rst)
        cnt <= cnt - CW'(1);
      if (ctl_wr)
        allow_audio <= req_q.dat[0];
      fetch_data <= mem[fetch_addr];
    end
  end

  // Store is not reset; same-word write/fetch returns the old word via NBA ordering.
  always_ff @(posedge ck) begin
    if (coef_wr)
      for (int b = 0; b < 4; b++)
        if (req_q.sel[b])
          mem[req_q.off[PROG_AW-1:0]][8*b +: 8] <= req_q.dat[8*b +: 8];
  end

endmodule

// File: tb/tb_dsp_wb_regs.sv
// Scoreboard bench for dsp_wb_regs: expected read data queued at drive, popped on ack.
module tb_dsp_wb_regs;

  logic        ck = 0, rst_n = 0;
  logic        wb_dbus_cyc = 0, wb_dbus_we = 0;
  logic [3:0]  wb_dbus_sel = 0;
  logic [31:0] wb_dbus_adr = 0, wb_dbus_dat = 0;
  logic        ack;
  logic [31:0] rdt;
  logic [7:0]  fetch_addr = 0;
  logic [31:0] fetch_data;
  logic        capt_we = 0;
  logic [31:0] capt_data = 0;
  logic        engine_ready = 0;
  logic        dsp_rst, allow_audio;

  dsp_wb_regs dut (
    .ck(ck), .rst_n(rst_n),
    .wb_dbus_cyc(wb_dbus_cyc), .wb_dbus_we(wb_dbus_we), .wb_dbus_sel(wb_dbus_sel),
    .wb_dbus_adr(wb_dbus_adr), .wb_dbus_dat(wb_dbus_dat),
    .ack(ack), .rdt(rdt),
    .fetch_addr(fetch_addr), .fetch_data(fetch_data),
    .capt_we(capt_we), .capt_data(capt_data),
    .engine_ready(engine_ready), .dsp_rst(dsp_rst), .allow_audio(allow_audio)
  );

  always #5 ck = ~ck;

  int n_chk = 0, n_fail = 0;
  int cyc_n = 0, ack_cnt = 0, rst_hi = 0, last_ack = 0, last_rst = 0;
  logic mon_we = 1'b1;
  logic [31:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // Bus monitor: pops the scoreboard on read acks, rdt must be 0 otherwise.
  always @(negedge ck) begin
    cyc_n++;
    if (rst_n) begin
      if (dsp_rst) begin rst_hi++; last_rst = cyc_n; end
      if (ack) begin
        ack_cnt++;
        last_ack = cyc_n;
        if (!mon_we) begin
          if (exp_q.size() == 0) chk("rd_unexpected", 32'(exp_q.size()), 32'd1);
          else chk("rd_data", rdt, exp_q.pop_front());
        end
      end else
        chk("rdt_idle", rdt, 32'd0);
    end
  end

  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input logic [31:0] exp, input logic capt);
    logic got;
    @(posedge ck); #1;
    mon_we = we;
    if (!we) exp_q.push_back(exp);
    wb_dbus_cyc = 1; wb_dbus_we = we; wb_dbus_adr = adr; wb_dbus_dat = dat; wb_dbus_sel = sel;
    if (capt) capt_we = 1;
    @(posedge ck); #1;
    capt_we = 0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge ck);
      got = ack;
    end
    if (!got) chk("ack_timeout", {31'b0, ack}, 32'd1);
    @(posedge ck); #1;
    wb_dbus_cyc = 0; wb_dbus_we = 0;
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    xfer(1'b1, adr, dat, sel, 32'd0, 1'b0);
  endtask

  task automatic rd(input logic [31:0] adr, input logic [31:0] exp, input logic capt);
    xfer(1'b0, adr, 32'd0, 4'hF, exp, capt);
  endtask

  int k0, r0, a1, a2;
  logic [31:0] coef_exp;

  initial begin
    repeat (3) @(posedge ck);
    @(negedge ck);
    chk("rst_ack", {31'b0, ack}, 32'd0);
    chk("rst_rdt", rdt, 32'd0);
    chk("rst_dsp_rst", {31'b0, dsp_rst}, 32'd0);
    chk("rst_allow", {31'b0, allow_audio}, 32'd0);
    chk("rst_fetch", fetch_data, 32'd0);
    rst_n = 1;

    // Program store write and fetch
    k0 = ack_cnt;
    wr(32'h6000_0004, 32'h4808_1234, 4'hF);
    chk("wr_one_ack", 32'(ack_cnt - k0), 32'd1);
    fetch_addr = 8'd1;
    @(posedge ck); #1;
    chk("fetch_w1", fetch_data, 32'h4808_1234);

`ifdef DSP_COEF_READBACK_EN
    coef_exp = 32'h4808_1234;
`else
    coef_exp = 32'h0;
`endif
    rd(32'h6000_0004, coef_exp, 1'b0);

    // Byte-lane gating
    wr(32'h6000_0004, 32'hFFFF_FFFF, 4'b0010);
    @(posedge ck); #1;
    chk("fetch_sel", fetch_data, 32'h4808_FF34);

    // Same-word write and fetch: old word first, new word next
    fetch_addr = 8'd2;
    wr(32'h6000_0008, 32'hAAAA_5555, 4'hF);
    @(posedge ck); #1;
    wr(32'h6000_0008, 32'h1357_9BDF, 4'hF);
    chk("fetch_old", fetch_data, 32'hAAAA_5555);
    @(posedge ck); #1;
    chk("fetch_new", fetch_data, 32'h1357_9BDF);

    // Unmapped region
    k0 = ack_cnt;
    wr(32'h7000_0000, 32'hFFFF_FFFF, 4'hF);
    rd(32'h7000_0000, 32'h0, 1'b0);
    chk("unmapped_acks", 32'(ack_cnt - k0), 32'd2);

    // Single reset pulse
    r0 = rst_hi;
    wr(32'h6300_0000, 32'h0, 4'hF);
    a1 = last_ack;
    repeat (8) @(posedge ck); #1;
    chk("rst_pulse_len", 32'(rst_hi - r0), 32'd4);
    chk("rst_pulse_end", 32'(last_rst - a1), 32'd4);

    // Extended pulse: reload while active
    r0 = rst_hi;
    wr(32'h6300_0000, 32'h0, 4'hF);
    a1 = last_ack;
    wr(32'h6300_0000, 32'h0, 4'hF);
    a2 = last_ack;
    repeat (10) @(posedge ck); #1;
    chk("rst_ext_len", 32'(rst_hi - r0), 32'(a2 - a1 + 4));
    chk("rst_ext_end", 32'(last_rst - a2), 32'd4);

    // Busy bit during pulse, engine_ready after
    wr(32'h6300_0000, 32'h0, 4'hF);
    rd(32'h6200_0000, 32'h4, 1'b0);
    repeat (8) @(posedge ck); #1;
    engine_ready = 1;
    rd(32'h6200_0000, 32'h1, 1'b0);

    // Capture register
    capt_data = 32'hDEAD_BEEF;
    @(posedge ck); #1 capt_we = 1;
    @(posedge ck); #1 capt_we = 0;
    rd(32'h6200_0004, 32'hDEAD_BEEF, 1'b0);
    capt_data = 32'h1234_5678;
    rd(32'h6200_0004, 32'hDEAD_BEEF, 1'b1);
    rd(32'h6200_0004, 32'h1234_5678, 1'b0);
    wr(32'h6200_0004, 32'h0BAD_F00D, 4'hF);
    rd(32'h6200_0004, 32'h1234_5678, 1'b0);

    // Control bit
    wr(32'h6200_0000, 32'h1, 4'hF);
    chk("allow_set", {31'b0, allow_audio}, 32'd1);
    rd(32'h6200_0000, 32'h3, 1'b0);

    // cyc held for 5 cycles gets a single ack
    @(posedge ck); #1;
    mon_we = 0;
    exp_q.push_back(32'h3);
    wb_dbus_cyc = 1; wb_dbus_we = 0; wb_dbus_adr = 32'h6200_0000;
    k0 = ack_cnt;
    repeat (5) @(posedge ck); #1;
    wb_dbus_cyc = 0;
    chk("hold_one_ack", 32'(ack_cnt - k0), 32'd1);

    // Reset mid-transfer while ack is high
    @(posedge ck); #1;
    exp_q.push_back(32'h3);
    wb_dbus_cyc = 1;
    @(posedge ck);
    @(negedge ck); #1;
    chk("pre_rst_ack", {31'b0, ack}, 32'd1);
    rst_n = 0;
    @(posedge ck); #1;
    chk("midrst_ack", {31'b0, ack}, 32'd0);
    chk("midrst_allow", {31'b0, allow_audio}, 32'd0);
    chk("midrst_rdt", rdt, 32'd0);
    wb_dbus_cyc = 0;
    rst_n = 1;
    rd(32'h6200_0000, 32'h1, 1'b0);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
